// File: rtl/rop3_pkg.sv
// Shared FSM state type and named ROP3 mode bytes for the rop3_stream engine.
package rop3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [7:0] BLACKNESS = 8'h00;
  localparam logic [7:0] DSTINVERT = 8'h55;
  localparam logic [7:0] SRCINVERT = 8'h66;
  localparam logic [7:0] SRCCOPY   = 8'hCC;
  localparam logic [7:0] PATCOPY   = 8'hF0;
  localparam logic [7:0] WHITENESS = 8'hFF;

endpackage

// File: rtl/rop3_core.sv
// Combinational per-bit ROP3 lookup: each result bit selects the mode bit
// indexed by {P,S,D} at the same position.
module rop3_core
  import rop3_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [7:0]   i_mode,
  input  logic [N-1:0] i_p,
  input  logic [N-1:0] i_s,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_result
);

  // Bit-sliced mode lookup; P is the most significant index bit.
  always_comb begin
    o_result = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      o_result[i] = i_mode[{i_p[i], i_s[i], i_d[i]}];
    end
  end

endmodule

// File: rtl/rop3_stream.sv
// Burst-oriented ROP3 engine with a two-stage valid/ready pipeline.
// Optional stall statistics port enabled by defining ROP3_STREAM_STATS_EN.
module rop3_stream
  import rop3_pkg::*;
#(
  parameter int N     = 32,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_mode,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     P,
  input  logic [N-1:0]     S,
  input  logic [N-1:0]     D,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     Result,
  output logic             out_last,
  output logic             busy,
  output logic             done
`ifdef ROP3_STREAM_STATS_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_mode;
  logic [LEN_W-1:0] r_cnt;

  logic [N-1:0]     r_s1_p;
  logic [N-1:0]     r_s1_s;
  logic [N-1:0]     r_s1_d;
  logic             r_s1_last;
  logic             r_s1_valid;

  logic [N-1:0]     r_result;
  logic             r_out_last;
  logic             r_out_valid;
  logic             r_done;

  logic             w_adv2;
  logic             w_cmd_fire;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_cnt_zero;
  logic [N-1:0]     w_core_result;

  assign w_adv2     = !r_out_valid || out_ready;
  assign cmd_ready  = (r_state == IDLE);
  assign in_ready   = (r_state == RUN) && (!r_s1_valid || w_adv2);
  assign busy       = (r_state != IDLE);
  assign w_cmd_fire = cmd_valid && cmd_ready;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;
  assign w_cnt_zero = (r_cnt == {LEN_W{1'b0}});

  assign out_valid  = r_out_valid;
  assign Result     = r_result;
  assign out_last   = r_out_last;
  assign done       = r_done;

  // Burst sequencing: command, input acceptance, then wait for the tagged last result.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_cmd_fire) w_state_nxt = RUN;
        else            w_state_nxt = IDLE;
      end
      RUN: begin
        if (w_in_fire && w_cnt_zero) w_state_nxt = DRAIN;
        else                         w_state_nxt = RUN;
      end
      DRAIN: begin
        if (w_out_fire && r_out_last) w_state_nxt = IDLE;
        else                          w_state_nxt = DRAIN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_out_fire && r_out_last;
    end
  end

  // Mode and remaining-word counter; the counter stops at zero so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode <= 8'h00;
      r_cnt  <= {LEN_W{1'b0}};
    end else if (w_cmd_fire) begin
      r_mode <= cmd_mode;
      r_cnt  <= cmd_len;
    end else if (w_in_fire && !w_cnt_zero) begin
      r_cnt  <= r_cnt - LEN_W'(1);
    end
  end

  // Stage 1: input register, tagged last when accepted at count zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_p     <= {N{1'b0}};
      r_s1_s     <= {N{1'b0}};
      r_s1_d     <= {N{1'b0}};
      r_s1_last  <= 1'b0;
      r_s1_valid <= 1'b0;
    end else if (w_in_fire) begin
      r_s1_p     <= P;
      r_s1_s     <= S;
      r_s1_d     <= D;
      r_s1_last  <= w_cnt_zero;
      r_s1_valid <= 1'b1;
    end else if (w_adv2) begin
      r_s1_valid <= 1'b0;
    end
  end

  rop3_core #(.N(N)) u_core (
    .i_mode   (r_mode),
    .i_p      (r_s1_p),
    .i_s      (r_s1_s),
    .i_d      (r_s1_d),
    .o_result (w_core_result)
  );

  // Stage 2: output register, frozen while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result    <= {N{1'b0}};
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_adv2) begin
      r_out_valid <= r_s1_valid;
      r_out_last  <= r_s1_valid && r_s1_last;
      if (r_s1_valid) r_result <= w_core_result;
    end
  end

`ifdef ROP3_STREAM_STATS_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of stalled output cycles, restarted by each new command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 16'h0000;
    end else if (w_cmd_fire) begin
      r_stall_cnt <= 16'h0000;
    end else if (r_out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
